mmio_bus_ctrl: RTL

- Memory-mapped bus controller between the cpu memory port (mem_cmd/mem_addr/write_data/read_data) and the 256x16 synchronous RAM, switches, LEDs and HEX display.
- Replaces the ad-hoc tri-state decode in the top level with:
  - a registered, single-driver read path
  - a bus_ready handshake
  - switch synchronisation
  - a free-running cycle counter
  - sticky error reporting for unmapped accesses

---
 rtl/mmio_bus_ctrl_if.sv | 33 +++
 rtl/mmio_bus_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: cpu memory-port bundle between the cpu and mmio_bus_ctrl.
//   mem_cmd    : 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 illegal (cpu -> ctrl)
//   mem_addr   : 9-bit word address (cpu -> ctrl)
//   write_data : 16-bit write data (cpu -> ctrl)
//   read_data  : 16-bit read data, always driven (ctrl -> cpu)
//   bus_ready  : one-cycle completion pulse (ctrl -> cpu)
//   bus_err    : sticky unmapped/illegal access flag (ctrl -> cpu)
interface mmio_bus_ctrl_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        bus_ready;
  logic        bus_err;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  bus_ready,
    input  bus_err
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output bus_ready,
    output bus_err
  );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: memory-mapped bus controller between the cpu memory port and the
// 256x16 synchronous RAM, slide switches, LED register and HEX display register.
// Each accepted request gets exactly one RESP cycle with bus_ready=1; read data is
// muxed from registered sources only, so read_data has a single driver at all times.
//   i_clk       : rising-edge clock
//   i_rst_n     : asynchronous active-low reset
//   bus         : cpu port (mmio_bus_ctrl_if.slave)
//   o_ram_addr  : RAM address (combinational from mem_addr)
//   o_ram_write : RAM write enable
//   o_ram_din   : RAM write data (combinational from write_data)
//   i_ram_dout  : RAM registered read data
//   i_sw        : raw asynchronous switches
//   o_led       : LED register
//   o_hex_value : HEX display register
module mmio_bus_ctrl #(
  parameter int unsigned RAM_AW   = 8,
  parameter logic [8:0]  LED_ADDR = 9'h100,
  parameter logic [8:0]  HEX_ADDR = 9'h120,
  parameter logic [8:0]  SW_ADDR  = 9'h140,
  parameter logic [8:0]  CNT_ADDR = 9'h180
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mmio_bus_ctrl_if.slave    bus,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic              o_ram_write,
  output logic [15:0]       o_ram_din,
  input  logic [15:0]       i_ram_dout,
  input  logic [7:0]        i_sw,
  output logic [7:0]        o_led,
  output logic [15:0]       o_hex_value
);

  typedef enum logic {StIdle, StResp} state_e;
  typedef enum logic [1:0] {SelZero, SelRam, SelIo} sel_e;

  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  state_e      r_state;
  state_e      w_state_next;
  sel_e        r_sel;
  logic [15:0] r_io_rdata;
  logic [15:0] r_cnt;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;
  logic [7:0]  r_led;
  logic [15:0] r_hex;
  logic        r_err;

  logic        w_accept;
  logic        w_cmd_rd;
  logic        w_cmd_wr;
  logic        w_hit_ram;
  logic        w_hit_led;
  logic        w_hit_hex;
  logic        w_hit_sw;
  logic        w_hit_cnt;
  logic        w_mapped;
  logic        w_ok;
  logic        w_bad;
  logic [15:0] w_io_rdata;
  logic [15:0] w_read_data;
  logic        w_bus_ready;

  // Decode
  assign w_cmd_rd  = (bus.mem_cmd == CmdRead);
  assign w_cmd_wr  = (bus.mem_cmd == CmdWrite);
  assign w_hit_ram = ~bus.mem_addr[8];
  assign w_hit_led = (bus.mem_addr == LED_ADDR);
  assign w_hit_hex = (bus.mem_addr == HEX_ADDR);
  assign w_hit_sw  = (bus.mem_addr == SW_ADDR);
  assign w_hit_cnt = (bus.mem_addr == CNT_ADDR);
  assign w_mapped  = w_hit_ram | w_hit_led | w_hit_hex | w_hit_sw | w_hit_cnt;

  // Any non-NONE command in IDLE is accepted, including illegal/unmapped ones,
  // so the cpu always sees a bus_ready pulse and never stalls.
  assign w_accept = (r_state == StIdle) && (bus.mem_cmd != 2'b00);
  assign w_ok     = w_accept && (w_cmd_rd || w_cmd_wr) && w_mapped;
  assign w_bad    = w_accept && !((w_cmd_rd || w_cmd_wr) && w_mapped);

  // RAM port
  assign o_ram_addr  = bus.mem_addr[RAM_AW-1:0];
  assign o_ram_din   = bus.write_data;
  assign o_ram_write = w_ok && w_cmd_wr && w_hit_ram;

  // I/O read source, captured at the acceptance edge
  always_comb begin
    w_io_rdata = 16'h0000;
    if (w_hit_led) begin
      w_io_rdata = {8'h00, r_led};
    end else if (w_hit_hex) begin
      w_io_rdata = r_hex;
    end else if (w_hit_sw) begin
      w_io_rdata = {8'h00, r_sw_sync};
    end else if (w_hit_cnt) begin
      w_io_rdata = r_cnt;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and response outputs
  always_comb begin
    w_state_next = r_state;
    w_bus_ready  = 1'b0;
    w_read_data  = 16'h0000;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
        w_bus_ready  = 1'b1;
        unique case (r_sel)
          SelRam:  w_read_data = i_ram_dout;
          SelIo:   w_read_data = r_io_rdata;
          default: w_read_data = 16'h0000;
        endcase
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel      <= SelZero;
      r_io_rdata <= 16'h0000;
      r_cnt      <= 16'h0000;
      r_sw_meta  <= 8'h00;
      r_sw_sync  <= 8'h00;
      r_led      <= 8'h00;
      r_hex      <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;

      // Clear wins over the free-running increment
      if (w_ok && w_cmd_wr && w_hit_cnt) begin
        r_cnt <= 16'h0000;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_bad) begin
        r_err <= 1'b1;
      end

      if (w_accept) begin
        r_sel      <= SelZero;
        r_io_rdata <= 16'h0000;
        if (w_ok && w_cmd_rd) begin
          if (w_hit_ram) begin
            r_sel <= SelRam;
          end else begin
            r_sel      <= SelIo;
            r_io_rdata <= w_io_rdata;
          end
        end
        if (w_ok && w_cmd_wr) begin
          if (w_hit_led) begin
            r_led <= bus.write_data[7:0];
          end
          if (w_hit_hex) begin
            r_hex <= bus.write_data;
          end
        end
      end
    end
  end

  assign bus.read_data = w_read_data;
  assign bus.bus_ready = w_bus_ready;
  assign bus.bus_err   = r_err;
  assign o_led         = r_led;
  assign o_hex_value   = r_hex;

endmodule
